// File: rtl/ovl_fabric_pkg.sv
// ---------------------------------------------------------------------------
// ovl_fabric_pkg
// Shared types and helpers for the OVL fire collection fabric.
//   ID_W      : checker index width for the default 8-checker fabric
//   evt_t     : one queued fire event {checker id, timestamp}
//   prio_t    : result of prio_enc {found, index}
//   prio_enc  : lowest-set-bit priority encoder over a 32-bit vector
// ---------------------------------------------------------------------------
package ovl_fabric_pkg;

    localparam int N_CHK_DFLT = 8;
    localparam int TS_W_DFLT  = 16;
    localparam int ID_W       = (N_CHK_DFLT > 1) ? $clog2(N_CHK_DFLT) : 1;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [TS_W_DFLT-1:0] ts;
    } evt_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } prio_t;

    // Scans downwards so the last assignment left standing is the lowest set bit.
    function automatic prio_t prio_enc(input logic [31:0] vec);
        prio_t res;
        res = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.idx   = 5'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ovl_evt_fifo.sv
// ---------------------------------------------------------------------------
// ovl_evt_fifo
// Synchronous FIFO with a valid/ready read side.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous flush (pointers back to empty)
//   push       : write push_data this cycle
//   push_data  : W-bit entry
//   out_valid  : FIFO not empty
//   out_ready  : consumer takes the head entry when out_valid is high
//   out_data   : head entry (zero while empty)
//   full       : occupancy == DEPTH
// ---------------------------------------------------------------------------
module ovl_evt_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         pop;
    logic         do_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // When full, a push is only legal alongside a pop; the head slot is read
    // out before the same slot is overwritten at the edge.
    assign do_push   = push & (~full | pop);
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ovl_fire_collector.sv
// ---------------------------------------------------------------------------
// ovl_fire_collector
// Collects single-bit OVL checker fire lines into sticky waiting bits, then
// serialises them, lowest index first, into an event FIFO of
// {checker id, timestamp} read over valid/ready.
//   clk, rst      : clock, synchronous active-high reset (highest priority)
//   enable        : capture enable (FIFO keeps draining when low)
//   fire_in       : per-checker fire
//   fire_mask     : 1 = checker participates
//   clear         : flush waiting bits, FIFO and coalesce count (not timestamp)
//   evt_valid/evt_ready/evt_id/evt_ts : event output handshake
//   waiting       : captured hits not yet pushed
//   coalesce_cnt  : saturating count of hits merged into already-set bits
//   fifo_full     : FIFO occupancy == FIFO_DEPTH
// ---------------------------------------------------------------------------
module ovl_fire_collector
    import ovl_fabric_pkg::*;
#(
    parameter int N_CHK      = N_CHK_DFLT,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = TS_W_DFLT,
    parameter int CNT_W      = 8,
    localparam int EVT_ID_W  = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [N_CHK-1:0]    fire_in,
    input  logic [N_CHK-1:0]    fire_mask,
    input  logic                clear,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [EVT_ID_W-1:0] evt_id,
    output logic [TS_W-1:0]     evt_ts,
    output logic [N_CHK-1:0]    waiting,
    output logic [CNT_W-1:0]    coalesce_cnt,
    output logic                fifo_full
);

    localparam int SUM_W = CNT_W + 6;

    logic [TS_W-1:0]          ts;
    logic [N_CHK-1:0]         hit;
    logic [N_CHK-1:0]         pushed_onehot;
    logic [N_CHK-1:0]         remain;
    logic [N_CHK-1:0]         coalesced;
    logic [N_CHK-1:0]         waiting_next;
    logic [31:0]              waiting_ext;
    prio_t                    pe;
    logic                     can_accept;
    logic                     push;
    logic [5:0]               n_coal;
    logic [SUM_W-1:0]         coal_sum;
    logic [CNT_W-1:0]         coal_next;
    logic [EVT_ID_W+TS_W-1:0] push_data;
    logic [EVT_ID_W+TS_W-1:0] head_data;

    assign hit = fire_in & fire_mask & {N_CHK{enable}};

    always_comb begin
        waiting_ext = '0;
        waiting_ext[N_CHK-1:0] = waiting;
    end

    assign pe         = prio_enc(waiting_ext);
    assign can_accept = ~fifo_full | (evt_valid & evt_ready);
    assign push       = pe.found & can_accept & ~clear;

    assign pushed_onehot = push ? (N_CHK'(1) << pe.idx) : '0;
    assign remain        = waiting & ~pushed_onehot;
    // A hit only counts as coalesced if its bit survives this cycle's push.
    assign coalesced     = hit & remain;
    assign waiting_next  = remain | hit;

    always_comb begin
        n_coal = '0;
        for (int i = 0; i < N_CHK; i++) begin
            n_coal = n_coal + 6'(coalesced[i]);
        end
    end

    assign coal_sum  = SUM_W'(coalesce_cnt) + SUM_W'(n_coal);
    assign coal_next = (coal_sum[SUM_W-1:CNT_W] != '0) ? {CNT_W{1'b1}} : coal_sum[CNT_W-1:0];

    assign push_data = {pe.idx[EVT_ID_W-1:0], ts};

    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            waiting      <= '0;
            coalesce_cnt <= '0;
        end else begin
            waiting      <= waiting_next;
            coalesce_cnt <= coal_next;
        end
    end

    ovl_evt_fifo #(
        .W     (EVT_ID_W + TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .out_valid (evt_valid),
        .out_ready (evt_ready),
        .out_data  (head_data),
        .full      (fifo_full)
    );

    assign evt_id = head_data[EVT_ID_W+TS_W-1:TS_W];
    assign evt_ts = head_data[TS_W-1:0];

endmodule

// File: tb/tb_ovl_fire_collector.sv
module tb_ovl_fire_collector;
    import ovl_fabric_pkg::*;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int TW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [N-1:0]  fire_in;
    logic [N-1:0]  fire_mask;
    logic          clear;
    logic          evt_valid;
    logic          evt_ready;
    logic [ID_W-1:0] evt_id;
    logic [TW-1:0] evt_ts;
    logic [N-1:0]  waiting;
    logic [CW-1:0] coalesce_cnt;
    logic          fifo_full;

    int        n_vec = 0;
    int        n_err = 0;
    evt_t      exp_q[$];
    evt_t      mon_e;
    logic [TW-1:0] tb_ts;
    int        t0;

    always #5 clk = ~clk;

    ovl_fire_collector #(
        .N_CHK      (N),
        .FIFO_DEPTH (D),
        .TS_W       (TW),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fire_in      (fire_in),
        .fire_mask    (fire_mask),
        .clear        (clear),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .evt_ts       (evt_ts),
        .waiting      (waiting),
        .coalesce_cnt (coalesce_cnt),
        .fifo_full    (fifo_full)
    );

    // Reference timestamp: counts edges since the last reset edge.
    always_ff @(posedge clk) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 1'b1;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic expect_evt(input int id, input int ts);
        evt_t e;
        e.id = ID_W'(id);
        e.ts = TW'(ts);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            tick();
            k++;
        end
        tick(3);
        chk(nm, exp_q.size(), 0);
    endtask

    // Fill the FIFO while stalled with checkers 0..3 (plus any extra bits).
    task automatic fill_stalled(input logic [N-1:0] pattern);
        evt_ready = 1'b0;
        t0 = int'(tb_ts);
        fire_in = pattern;
        for (int i = 0; i < 4; i++) expect_evt(i, t0 + 1 + i);
        tick();
        fire_in = '0;
        tick(4);
    endtask

    // Scoreboard monitor: every transfer pops one expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && evt_valid && evt_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL evt_unexpected: got id %0d ts %0d, required no event", evt_id, evt_ts);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (evt_id !== mon_e.id || evt_ts !== mon_e.ts) begin
                        n_err++;
                        $display("FAIL evt: got id %0d ts %0d, required id %0d ts %0d",
                                 evt_id, evt_ts, mon_e.id, mon_e.ts);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; enable = 1'b1; fire_in = '0; fire_mask = '1;
        clear = 1'b0; evt_ready = 1'b0;
        tick(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_waiting", waiting, 0);
        chk("rst_coalesce", coalesce_cnt, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_ts", evt_ts, 0);
        rst = 1'b0;

        // Single fire at ts=10
        evt_ready = 1'b1;
        k = 0;
        while (tb_ts != 16'd10 && k < 100) begin
            tick();
            k++;
        end
        fire_in = 8'b0000_0100;
        expect_evt(2, 11);
        tick();
        fire_in = '0;
        chk("single_wait_c1", waiting, 8'h04);
        chk("single_valid_c1", evt_valid, 0);
        tick();
        chk("single_valid_c2", evt_valid, 1);
        chk("single_wait_c2", waiting, 0);
        drain("single_drain");

        // Simultaneous fires 0xA1
        t0 = int'(tb_ts);
        fire_in = 8'hA1;
        expect_evt(0, t0 + 1);
        expect_evt(5, t0 + 2);
        expect_evt(7, t0 + 3);
        tick();
        fire_in = '0;
        chk("simul_wait", waiting, 8'hA1);
        drain("simul_drain");
        chk("simul_coalesce", coalesce_cnt, 0);

        // Backpressure and coalesce
        fill_stalled(8'h1F);
        chk("bp_full", fifo_full, 1);
        chk("bp_wait", waiting, 8'h10);
        for (int i = 0; i < 3; i++) begin
            fire_in = 8'h10;
            tick();
        end
        fire_in = '0;
        chk("bp_full2", fifo_full, 1);
        chk("bp_wait2", waiting, 8'h10);
        chk("bp_coalesce", coalesce_cnt, 3);
        chk("bp_valid", evt_valid, 1);
        chk("bp_id", evt_id, 0);
        chk("bp_ts", evt_ts, t0 + 1);
        tick(2);
        chk("bp_id_stable", evt_id, 0);
        chk("bp_ts_stable", evt_ts, t0 + 1);
        evt_ready = 1'b1;
        expect_evt(4, int'(tb_ts));
        tick();
        chk("bp_full_after_pop_push", fifo_full, 1);
        chk("bp_wait_after", waiting, 0);
        drain("bp_drain");

        // Full with simultaneous pop and push, waiting=0x80
        fill_stalled(8'h8F);
        chk("pp_wait", waiting, 8'h80);
        chk("pp_full", fifo_full, 1);
        evt_ready = 1'b1;
        expect_evt(7, int'(tb_ts));
        tick();
        chk("pp_full_hold", fifo_full, 1);
        chk("pp_wait_after", waiting, 0);
        tick();
        chk("pp_full_drop", fifo_full, 0);
        drain("pp_drain");

        // Mask
        fire_mask = 8'hFE;
        fire_in = 8'h01;
        tick();
        fire_in = '0;
        tick(3);
        chk("mask_valid", evt_valid, 0);
        chk("mask_wait", waiting, 0);
        fire_mask = '1;

        // Enable low: ignore hits, keep draining
        fill_stalled(8'h0F);
        chk("en_full", fifo_full, 1);
        enable = 1'b0;
        fire_in = 8'hFF;
        evt_ready = 1'b1;
        tick();
        chk("en_wait", waiting, 0);
        drain("en_drain");
        chk("en_full_after", fifo_full, 0);
        chk("en_wait_after", waiting, 0);
        enable = 1'b1;
        fire_in = '0;

        // Clear mid-operation
        evt_ready = 1'b0;
        t0 = int'(tb_ts);
        fire_in = 8'h07;
        for (int i = 0; i < 3; i++) expect_evt(i, t0 + 1 + i);
        tick();
        fire_in = '0;
        tick(3);
        chk("clr_pre_valid", evt_valid, 1);
        chk("clr_pre_coalesce", coalesce_cnt, 3);
        clear = 1'b1;
        fire_in = 8'h02;
        exp_q.delete();
        tick();
        clear = 1'b0;
        fire_in = '0;
        chk("clr_valid", evt_valid, 0);
        chk("clr_wait", waiting, 0);
        chk("clr_coalesce", coalesce_cnt, 0);
        chk("clr_full", fifo_full, 0);
        tick();
        chk("clr_wait2", waiting, 0);
        evt_ready = 1'b1;
        t0 = int'(tb_ts);
        fire_in = 8'h01;
        expect_evt(0, t0 + 1);
        tick();
        fire_in = '0;
        drain("clr_ts_continues");

        // Reset mid-operation
        evt_ready = 1'b0;
        fire_in = 8'h07;
        tick();
        fire_in = '0;
        tick(3);
        rst = 1'b1;
        fire_in = 8'h02;
        exp_q.delete();
        tick();
        rst = 1'b0;
        fire_in = '0;
        chk("rst2_valid", evt_valid, 0);
        chk("rst2_wait", waiting, 0);
        chk("rst2_coalesce", coalesce_cnt, 0);
        chk("rst2_full", fifo_full, 0);
        chk("rst2_id", evt_id, 0);
        chk("rst2_ts", evt_ts, 0);
        evt_ready = 1'b1;
        fire_in = 8'h01;
        expect_evt(0, 1);
        tick();
        fire_in = '0;
        drain("rst2_ts_restart");

        // Popcount coalesce and saturation
        fill_stalled(8'h1F);
        fire_in = 8'h30;
        tick();
        fire_in = 8'h30;
        tick();
        fire_in = '0;
        chk("pc_coalesce", coalesce_cnt, 3);
        chk("pc_wait", waiting, 8'h30);
        fire_in = 8'h10;
        tick(300);
        fire_in = '0;
        chk("sat_coalesce", coalesce_cnt, 255);
        evt_ready = 1'b1;
        expect_evt(4, int'(tb_ts));
        expect_evt(5, int'(tb_ts) + 1);
        drain("sat_drain");
        chk("sat_hold", coalesce_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
